// File: rtl/pid_multichannel_if.sv
// Sample, result and configuration signals of the multichannel PID controller.
// The slave modport is the controller; the master modport is whoever feeds and drains it.
interface pid_multichannel_if #(
    parameter int unsigned D_WIDTH = 32,
    parameter int unsigned CW      = 2
);
    logic                      cfg_we;
    logic        [D_WIDTH-1:0] cfg_addr;
    logic        [D_WIDTH-1:0] cfg_data;
    logic                      in_valid;
    logic                      in_ready;
    logic        [CW-1:0]      in_ch;
    logic signed [D_WIDTH-1:0] target;
    logic signed [D_WIDTH-1:0] measurement;
    logic                      out_valid;
    logic                      out_ready;
    logic        [CW-1:0]      out_ch;
    logic signed [D_WIDTH-1:0] out_data;
    logic                      out_sat;

    modport master (
        output cfg_we, cfg_addr, cfg_data, in_valid, in_ch, target, measurement, out_ready,
        input  in_ready, out_valid, out_ch, out_data, out_sat
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, in_valid, in_ch, target, measurement, out_ready,
        output in_ready, out_valid, out_ch, out_data, out_sat
    );
endinterface

// File: rtl/pid_multichannel.sv
// Time-multiplexed PID controller: N_CH independent loops share one signed multiplier,
// with per-channel gains/history, dynamic integrator clamping and a saturated output.
module pid_multichannel #(
    parameter int unsigned D_WIDTH = 32,
    parameter int unsigned Q_BITS  = 10,
    parameter int unsigned N_CH    = 4,
    parameter int          LIM_MAX = 100,
    parameter int          LIM_MIN = -100,
    parameter int unsigned CW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input logic               clk_i,
    input logic               rst_i,
    pid_multichannel_if.slave bus_io
);
    // Wide enough for a D_WIDTH x (D_WIDTH+1) product and every sum below without wrap.
    localparam int unsigned PW = 2 * D_WIDTH + 2;

    typedef logic signed [D_WIDTH-1:0] data_t;
    typedef logic signed [PW-1:0]      wide_t;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MUL_P  = 3'd1;
    localparam logic [2:0] S_MUL_I  = 3'd2;
    localparam logic [2:0] S_MUL_D1 = 3'd3;
    localparam logic [2:0] S_MUL_D2 = 3'd4;
    localparam logic [2:0] S_SUM    = 3'd5;
    localparam logic [2:0] S_OUT    = 3'd6;

    localparam data_t DMAX = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam data_t DMIN = {1'b1, {(D_WIDTH-1){1'b0}}};
    localparam wide_t LMAX = wide_t'(LIM_MAX);
    localparam wide_t LMIN = wide_t'(LIM_MIN);
    localparam logic [D_WIDTH-1:0] GAIN_END = D_WIDTH'(4 * N_CH);
    localparam logic [D_WIDTH-1:0] CLR_END  = D_WIDTH'(5 * N_CH);

    function automatic wide_t sx(input data_t v);
        return wide_t'(v);
    endfunction

    function automatic data_t sat(input wide_t v);
        if (v > sx(DMAX)) return DMAX;
        if (v < sx(DMIN)) return DMIN;
        return v[D_WIDTH-1:0];
    endfunction

    data_t kp_q [N_CH];
    data_t ki_q [N_CH];
    data_t kd1_q[N_CH];
    data_t kd2_q[N_CH];
    data_t iacc_q[N_CH];
    data_t perr_q[N_CH];
    data_t pd_q  [N_CH];

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] ch_q, ch_d;
    data_t         err_q, err_d;
    data_t         kps_q, kps_d, kis_q, kis_d, kd1s_q, kd1s_d, kd2s_q, kd2s_d;
    data_t         iaccs_q, iaccs_d, perrs_q, perrs_d, pds_q, pds_d;
    data_t         p_q, p_d, ic_q, ic_d, d_q, d_d;
    data_t         out_q, out_d;
    logic [CW-1:0] out_ch_q, out_ch_d;
    logic          out_sat_q, out_sat_d;

    // Shared multiplier: operands are steered by the current step.
    data_t mul_a;
    wide_t mul_b, prod, prod_sh;
    data_t fx_res;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (state_q)
            S_MUL_P:  begin mul_a = kps_q;  mul_b = sx(err_q);                end
            S_MUL_I:  begin mul_a = kis_q;  mul_b = sx(err_q) + sx(perrs_q);  end
            S_MUL_D1: begin mul_a = kd1s_q; mul_b = sx(err_q) - sx(perrs_q);  end
            S_MUL_D2: begin mul_a = kd2s_q; mul_b = sx(pds_q);                end
            default:  ;
        endcase
    end

    assign prod    = sx(mul_a) * mul_b;
    assign prod_sh = prod >>> Q_BITS;
    assign fx_res  = sat(prod_sh);

    // Anti-windup: the integrator may only use the headroom that p leaves inside the limits.
    wide_t p_w, hi, lo, ic_w, ic_cw, s_w;
    data_t ic_clamp;

    always_comb begin
        p_w      = sx(p_q);
        hi       = (LMAX > p_w) ? LMAX - p_w : '0;
        lo       = (LMIN < p_w) ? LMIN - p_w : '0;
        ic_w     = sx(ic_q);
        ic_cw    = (ic_w > hi) ? hi : ((ic_w < lo) ? lo : ic_w);
        ic_clamp = ic_cw[D_WIDTH-1:0];
        s_w      = p_w + ic_cw + sx(d_q);
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        err_d     = err_q;
        kps_d     = kps_q;
        kis_d     = kis_q;
        kd1s_d    = kd1s_q;
        kd2s_d    = kd2s_q;
        iaccs_d   = iaccs_q;
        perrs_d   = perrs_q;
        pds_d     = pds_q;
        p_d       = p_q;
        ic_d      = ic_q;
        d_d       = d_q;
        out_d     = out_q;
        out_ch_d  = out_ch_q;
        out_sat_d = out_sat_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus_io.in_valid) begin
                    ch_d    = bus_io.in_ch;
                    // The error itself is held saturated to D_WIDTH.
                    err_d   = sat(sx(bus_io.target) - sx(bus_io.measurement));
                    kps_d   = kp_q[bus_io.in_ch];
                    kis_d   = ki_q[bus_io.in_ch];
                    kd1s_d  = kd1_q[bus_io.in_ch];
                    kd2s_d  = kd2_q[bus_io.in_ch];
                    iaccs_d = iacc_q[bus_io.in_ch];
                    perrs_d = perr_q[bus_io.in_ch];
                    pds_d   = pd_q[bus_io.in_ch];
                    state_d = S_MUL_P;
                end
            end
            S_MUL_P: begin
                p_d     = fx_res;
                state_d = S_MUL_I;
            end
            S_MUL_I: begin
                ic_d    = sat(sx(iaccs_q) + sx(fx_res));
                state_d = S_MUL_D1;
            end
            S_MUL_D1: begin
                d_d     = fx_res;
                state_d = S_MUL_D2;
            end
            S_MUL_D2: begin
                d_d     = sat(sx(d_q) + sx(fx_res));
                state_d = S_SUM;
            end
            S_SUM: begin
                out_ch_d  = ch_q;
                out_sat_d = 1'b1;
                if (s_w > LMAX) begin
                    out_d = LMAX[D_WIDTH-1:0];
                end else if (s_w < LMIN) begin
                    out_d = LMIN[D_WIDTH-1:0];
                end else begin
                    out_d     = s_w[D_WIDTH-1:0];
                    out_sat_d = 1'b0;
                end
                state_d = S_OUT;
            end
            S_OUT: begin
                if (bus_io.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic          gain_we, clr_we, commit;
    logic [CW-1:0] gain_ch, clr_ch;
    logic [1:0]    gain_sel;

    assign gain_we  = bus_io.cfg_we && (bus_io.cfg_addr < GAIN_END);
    assign gain_ch  = bus_io.cfg_addr[CW+1:2];
    assign gain_sel = bus_io.cfg_addr[1:0];
    assign clr_we   = bus_io.cfg_we && (bus_io.cfg_addr >= GAIN_END) && (bus_io.cfg_addr < CLR_END);
    assign clr_ch   = CW'(bus_io.cfg_addr - GAIN_END);
    assign commit   = (state_q == S_SUM);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_CH; i++) begin
                kp_q[i]   <= '0;
                ki_q[i]   <= '0;
                kd1_q[i]  <= '0;
                kd2_q[i]  <= '0;
                iacc_q[i] <= '0;
                perr_q[i] <= '0;
                pd_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (gain_we && gain_ch == CW'(i)) begin
                    unique case (gain_sel)
                        2'd0: kp_q[i]  <= bus_io.cfg_data;
                        2'd1: ki_q[i]  <= bus_io.cfg_data;
                        2'd2: kd1_q[i] <= bus_io.cfg_data;
                        2'd3: kd2_q[i] <= bus_io.cfg_data;
                        default: ;
                    endcase
                end
                if (commit && ch_q == CW'(i)) begin
                    iacc_q[i] <= ic_clamp;
                    perr_q[i] <= err_q;
                    pd_q[i]   <= d_q;
                end
                // A clear landing on the commit cycle must win, so it is assigned last.
                if (clr_we && clr_ch == CW'(i)) begin
                    iacc_q[i] <= '0;
                    perr_q[i] <= '0;
                    pd_q[i]   <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            err_q     <= '0;
            kps_q     <= '0;
            kis_q     <= '0;
            kd1s_q    <= '0;
            kd2s_q    <= '0;
            iaccs_q   <= '0;
            perrs_q   <= '0;
            pds_q     <= '0;
            p_q       <= '0;
            ic_q      <= '0;
            d_q       <= '0;
            out_q     <= '0;
            out_ch_q  <= '0;
            out_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            err_q     <= err_d;
            kps_q     <= kps_d;
            kis_q     <= kis_d;
            kd1s_q    <= kd1s_d;
            kd2s_q    <= kd2s_d;
            iaccs_q   <= iaccs_d;
            perrs_q   <= perrs_d;
            pds_q     <= pds_d;
            p_q       <= p_d;
            ic_q      <= ic_d;
            d_q       <= d_d;
            out_q     <= out_d;
            out_ch_q  <= out_ch_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign bus_io.in_ready  = (state_q == S_IDLE);
    assign bus_io.out_valid = (state_q == S_OUT);
    assign bus_io.out_ch    = out_ch_q;
    assign bus_io.out_data  = out_q;
    assign bus_io.out_sat   = out_sat_q;
endmodule

// File: tb/tb_pid_multichannel.sv
// Bench for pid_multichannel: a per-channel arithmetic model predicts every result,
// a compare process checks each output cycle, and directed steps pin known values.
module tb_pid_multichannel;
    localparam int unsigned DW  = 32;
    localparam int unsigned QB  = 10;
    localparam int unsigned NCH = 4;
    localparam int unsigned CWB = 2;
    localparam longint LMAX = 100;
    localparam longint LMIN = -100;
    localparam longint DMAX = 2147483647;
    localparam longint DMIN = -longint'(2147483647) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pid_multichannel_if #(.D_WIDTH(DW), .CW(CWB)) bus ();

    pid_multichannel #(
        .D_WIDTH(DW), .Q_BITS(QB), .N_CH(NCH), .LIM_MAX(100), .LIM_MIN(-100), .CW(CWB)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     ch;
        longint out;
        bit     sat;
    } res_t;

    int     n_cmp = 0;
    int     n_fail = 0;
    int     acc_cnt = 0;
    int     done_cnt = 0;
    longint last_out = 0;
    longint last_sat = 0;
    longint last_ch = 0;
    time    accept_t = 0;
    res_t   exp_q[$];
    longint m_kp[NCH], m_ki[NCH], m_kd1[NCH], m_kd2[NCH];
    longint m_iacc[NCH], m_perr[NCH], m_pd[NCH];

    function automatic void check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic longint msat(input longint v);
        if (v > DMAX) return DMAX;
        if (v < DMIN) return DMIN;
        return v;
    endfunction

    function automatic longint fx(input longint a, input longint b);
        return msat((a * b) >>> QB);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_kp[i] = 0; m_ki[i] = 0; m_kd1[i] = 0; m_kd2[i] = 0;
            m_iacc[i] = 0; m_perr[i] = 0; m_pd[i] = 0;
        end
    endfunction

    function automatic void model_cfg(input longint addr, input longint data);
        if (addr >= 0 && addr < 4 * NCH) begin
            case (addr % 4)
                0: m_kp[addr / 4] = data;
                1: m_ki[addr / 4] = data;
                2: m_kd1[addr / 4] = data;
                default: m_kd2[addr / 4] = data;
            endcase
        end else if (addr >= 4 * NCH && addr < 5 * NCH) begin
            m_iacc[addr - 4 * NCH] = 0;
            m_perr[addr - 4 * NCH] = 0;
            m_pd[addr - 4 * NCH] = 0;
        end
    endfunction

    function automatic void model_step(input int ch, input longint tgt, input longint meas);
        longint err, p, ic, d, hi, lo, s;
        res_t r;
        err = msat(tgt - meas);
        p   = fx(m_kp[ch], err);
        ic  = msat(m_iacc[ch] + fx(m_ki[ch], err + m_perr[ch]));
        d   = fx(m_kd1[ch], err - m_perr[ch]);
        d   = msat(d + fx(m_kd2[ch], m_pd[ch]));
        hi  = (LMAX > p) ? LMAX - p : 0;
        lo  = (LMIN < p) ? LMIN - p : 0;
        if (ic > hi) ic = hi;
        else if (ic < lo) ic = lo;
        s = p + ic + d;
        r.sat = 1'b0;
        if (s > LMAX) begin s = LMAX; r.sat = 1'b1; end
        else if (s < LMIN) begin s = LMIN; r.sat = 1'b1; end
        r.ch  = ch;
        r.out = s;
        exp_q.push_back(r);
        m_iacc[ch] = ic;
        m_perr[ch] = err;
        m_pd[ch]   = d;
    endfunction

    // Compare every output cycle against the oldest outstanding prediction.
    always @(negedge clk) begin
        if (!rst) begin
            check("ready_valid_exclusive", longint'(bus.in_ready && bus.out_valid), 0);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    check("out", longint'(bus.out_data), exp_q[0].out);
                    check("out_ch", longint'(bus.out_ch), longint'(exp_q[0].ch));
                    check("out_sat", longint'(bus.out_sat), longint'(exp_q[0].sat));
                    if (bus.out_ready) begin
                        last_out = longint'(bus.out_data);
                        last_sat = longint'(bus.out_sat);
                        last_ch  = longint'(bus.out_ch);
                        void'(exp_q.pop_front());
                        done_cnt++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input longint addr, input longint data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = DW'(addr);
        bus.cfg_data = DW'(data);
        @(posedge clk);
        model_cfg(addr, data);
        #1;
        bus.cfg_we = 1'b0;
    endtask

    task automatic send(input int ch, input longint tgt, input longint meas);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            check("send_in_ready_timeout", 0, 1);
        end else begin
            bus.in_valid    = 1'b1;
            bus.in_ch       = CWB'(ch);
            bus.target      = DW'(tgt);
            bus.measurement = DW'(meas);
            @(posedge clk);
            model_step(ch, tgt, meas);
            acc_cnt++;
            accept_t = $time;
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt != acc_cnt && n < 200) begin
            tick();
            n++;
        end
        check("result_handshake", longint'(done_cnt), longint'(acc_cnt));
    endtask

    task automatic chk_reset_outputs();
        check("rst_in_ready", longint'(bus.in_ready), 1);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_ch", longint'(bus.out_ch), 0);
        check("rst_out", longint'(bus.out_data), 0);
        check("rst_out_sat", longint'(bus.out_sat), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        time t0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.in_valid = 1'b0; bus.in_ch = '0; bus.target = '0; bus.measurement = '0;
        bus.out_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;
        tick();

        // Proportional only; out_valid must be seen at the sixth edge after accept.
        cfg_write(0, 1024);
        send(0, 50, 20);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("out_valid_cycle", longint'(n + 1), 6);
        wait_done();
        check("t1_out_lit", last_out, 30);
        check("t1_sat_lit", last_sat, 0);

        // Back-to-back samples with out_ready held high: one accept every 7 cycles.
        send(0, 50, 20);
        t0 = accept_t;
        send(0, 50, 20);
        check("throughput_cycles", longint'((accept_t - t0) / 10), 7);
        wait_done();

        // Output saturation in both directions.
        cfg_write(0, 4096);
        send(0, 70, 20);
        wait_done();
        check("t2_hi_out_lit", last_out, 100);
        check("t2_hi_sat_lit", last_sat, 1);
        send(0, -30, 20);
        wait_done();
        check("t2_lo_out_lit", last_out, -100);
        check("t2_lo_sat_lit", last_sat, 1);

        // Integrator ramps then stops at the limit without winding up.
        cfg_write(5, 512);
        for (int i = 0; i < 12; i++) begin
            send(1, 10, 0);
            wait_done();
            check("t3_ramp_lit", last_out, (i < 10) ? longint'(5 + 10 * i) : 100);
        end
        send(1, 0, 10);
        wait_done();
        check("t3_reverse1_lit", last_out, 100);
        send(1, 0, 10);
        wait_done();
        check("t3_reverse2_lit", last_out, 90);

        // Two channels with different gains, interleaved.
        cfg_write(0, 2048); cfg_write(1, 256); cfg_write(2, 512); cfg_write(3, 128);
        cfg_write(8, 1024); cfg_write(10, 1024);
        send(2, 7, -3);
        wait_done();
        check("t4_ch2_first_lit", last_out, 20);
        check("t4_ch2_ch_lit", last_ch, 2);
        begin
            int     tch[8] = '{0, 2, 0, 0, 2, 2, 0, 2};
            longint ttg[8] = '{12, -4, -3, 40, 9, 60, -80, 0};
            longint tms[8] = '{0, 5, 2, 1, 9, -10, 3, 33};
            for (int i = 0; i < 8; i++) begin
                send(tch[i], ttg[i], tms[i]);
                wait_done();
            end
        end
        // Gain written while a ch2 sample is in flight applies from the next sample only.
        send(2, 15, 0);
        cfg_write(8, 3072);
        wait_done();
        cfg_write(20, 999);
        cfg_write(100, 5);
        send(2, 15, 0);
        wait_done();
        send(0, 3, 1);
        wait_done();

        // Result held while out_ready is low; new samples are refused.
        bus.out_ready = 1'b0;
        send(0, 10, 0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_ch = 2'd3; bus.target = 77; bus.measurement = 0;
            tick();
            check("t5_in_ready_low", longint'(bus.in_ready), 0);
            check("t5_out_valid_held", longint'(bus.out_valid), 1);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        wait_done();
        check("t5_back_idle", longint'(bus.in_ready), 1);
        repeat (3) tick();
        check("t5_no_extra_sample", longint'(bus.out_valid), 0);

        // Clear of ch1 landing on its SUM cycle wins over the commit.
        send(1, 10, 0);
        repeat (4) @(posedge clk);
        #1;
        bus.cfg_we = 1'b1; bus.cfg_addr = 32'd17; bus.cfg_data = '0;
        @(posedge clk);
        model_cfg(17, 0);
        #1;
        bus.cfg_we = 1'b0;
        wait_done();
        send(1, 10, 0);
        wait_done();
        check("t6_after_clear_lit", last_out, 5);

        // Reset in the middle of a sample.
        send(0, 50, 20);
        tick();
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        model_reset();
        exp_q.delete();
        acc_cnt = 0;
        done_cnt = 0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        send(0, 50, 20);
        wait_done();
        check("t6_gains_cleared_lit", last_out, 0);
        cfg_write(0, 1024);
        send(0, 50, 20);
        wait_done();
        check("t6_after_reset_lit", last_out, 30);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
